// File: rtl/imm_extract_stage.sv
// Immediate extraction pipeline stage: decodes the imm type, extends the immediate to XLEN and adds it to the PC.
// The result is held in a valid/ready output register, optionally backed by a second skid entry.
module imm_extract_stage #(
  parameter int XLEN      = 32,
  parameter bit AUTO_TYPE = 1'b1,
  parameter bit SKID      = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ir,
  input  logic [XLEN-1:0] in_pc,
  input  logic [2:0]      in_imm_type,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic [2:0]      out_type,
  output logic            out_illegal
);

  // state   | meaning
  // S_EMPTY | nothing buffered
  // S_ONE   | output register holds a word
  // S_TWO   | output register and skid entry both hold words
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  localparam logic [2:0] T_I     = 3'b000;
  localparam logic [2:0] T_B     = 3'b001;
  localparam logic [2:0] T_S     = 3'b010;
  localparam logic [2:0] T_U     = 3'b011;
  localparam logic [2:0] T_J     = 3'b100;
  localparam logic [2:0] T_SHAMT = 3'b101;
  localparam logic [2:0] T_CSR   = 3'b110;
  localparam logic [2:0] T_NONE  = 3'b111;

  localparam int PW = 2 * XLEN + 4;

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [2:0]      w_auto_type;
  logic            w_auto_ill;
  logic [2:0]      w_type;
  logic            w_ill;
  logic [5:0]      w_sh6;
  logic [63:0]     w_imm64;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_tgt;
  logic [PW-1:0]   w_pay;
  logic            w_acc;
  logic            w_drn;

  logic [1:0]      r_state;
  logic            r_rdy;
  logic [PW-1:0]   r_out;
  logic [PW-1:0]   r_skid;

  assign w_opc = in_ir[6:0];
  assign w_f3  = in_ir[14:12];

  always_comb begin
    w_auto_type = T_NONE;
    w_auto_ill  = 1'b0;
    case (w_opc)
      7'h13:               w_auto_type = (w_f3 == 3'b001 || w_f3 == 3'b101) ? T_SHAMT : T_I;
      7'h03, 7'h67, 7'h0F: w_auto_type = T_I;
      7'h23:               w_auto_type = T_S;
      7'h63:               w_auto_type = T_B;
      7'h37, 7'h17:        w_auto_type = T_U;
      7'h6F:               w_auto_type = T_J;
      7'h73:               w_auto_type = w_f3[2] ? T_CSR : T_I;
      7'h33:               w_auto_type = T_NONE;
      7'h1B: begin
        if (XLEN == 64) w_auto_type = (w_f3 == 3'b001 || w_f3 == 3'b101) ? T_SHAMT : T_I;
        else            w_auto_ill  = 1'b1;
      end
      default:             w_auto_ill  = 1'b1;
    endcase
  end

  assign w_type = AUTO_TYPE ? w_auto_type : in_imm_type;
  assign w_ill  = AUTO_TYPE ? w_auto_ill : 1'b0;

  // OP-IMM-32 shifts are word-sized even on RV64, so only 5 shamt bits apply there
  assign w_sh6 = (XLEN == 64 && w_opc != 7'h1B) ? in_ir[25:20] : {1'b0, in_ir[24:20]};

  always_comb begin
    w_imm64 = 64'd0;
    case (w_type)
      T_I:     w_imm64 = {{52{in_ir[31]}}, in_ir[31:20]};
      T_B:     w_imm64 = {{51{in_ir[31]}}, in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0};
      T_S:     w_imm64 = {{52{in_ir[31]}}, in_ir[31:25], in_ir[11:7]};
      T_U:     w_imm64 = {{32{in_ir[31]}}, in_ir[31:12], 12'd0};
      T_J:     w_imm64 = {{43{in_ir[31]}}, in_ir[31], in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0};
      T_SHAMT: w_imm64 = {58'd0, w_sh6};
      T_CSR:   w_imm64 = {59'd0, in_ir[19:15]};
      default: w_imm64 = 64'd0;
    endcase
  end

  assign w_imm = w_imm64[XLEN-1:0];
  assign w_tgt = in_pc + w_imm;
  assign w_pay = {w_imm, w_tgt, w_type, w_ill};

  assign out_valid = (r_state != S_EMPTY);
  assign in_ready  = (SKID ? r_rdy : (r_state == S_EMPTY || out_ready)) & ~rst;
  assign w_acc     = in_valid & in_ready;
  assign w_drn     = out_valid & out_ready;

  // Without SKID, in_ready in S_ONE implies out_ready, so S_TWO is never entered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_rdy   <= 1'b1;
      r_out   <= '0;
      r_skid  <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_acc) begin
            r_out   <= w_pay;
            r_state <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_acc && w_drn) begin
            r_out <= w_pay;
          end else if (w_acc) begin
            r_skid  <= w_pay;
            r_state <= S_TWO;
            r_rdy   <= 1'b0;
          end else if (w_drn) begin
            r_state <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_drn) begin
            r_out   <= r_skid;
            r_state <= S_ONE;
            r_rdy   <= 1'b1;
          end
        end
        default: begin
          r_state <= S_EMPTY;
          r_rdy   <= 1'b1;
        end
      endcase
    end
  end

  assign out_imm     = r_out[PW-1 -: XLEN];
  assign out_target  = r_out[XLEN+3 -: XLEN];
  assign out_type    = r_out[3:1];
  assign out_illegal = r_out[0];

endmodule
